alu_nbit_seq: RTL

ALU_NBIT_SEQ -- requirements
Module: alu_nbit_seq

---
 rtl/alu_nbit_seq.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_nbit_seq.sv
// Multi-cycle ALU: logic/add/compare finish in one cycle, shifts take one cycle
// per bit position, and multiply runs a WIDTH-step shift-add loop.
module alu_nbit_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BNegate,
    input  logic [2:0]       ALUOp,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             Zero,
    output logic             Overflow
);

    localparam int CW = SHW + 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_SLT = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic             r_neg;
    logic [2:0]       r_op;
    logic [CW-1:0]    r_cnt;

    logic             w_capture;
    logic             w_last;
    logic [CW-1:0]    w_cnt_init;
    logic [WIDTH-1:0] w_bop;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic [WIDTH-1:0] w_sh;
    logic             w_sh_out;
    logic [WIDTH:0]   w_madd;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;

    assign w_capture = (r_state == S_IDLE) && Start;
    assign w_last    = (r_cnt <= CW'(1));

    always_comb begin
        w_cnt_init = CW'(1);
        if (ALUOp == OP_SHL || ALUOp == OP_SHR)
            w_cnt_init = {1'b0, B[SHW-1:0]};
        else if (ALUOp == OP_MUL)
            w_cnt_init = CW'(WIDTH);
    end

    // FSM state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (Start)  w_state_nxt = S_RUN;
            S_RUN:  if (w_last) w_state_nxt = S_IDLE;
            default:            w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        Busy = (r_state == S_RUN);
    end

    // Working registers carry no reset: they are reloaded on every capture.
    always_ff @(posedge Clk) begin
        if (w_capture) begin
            r_a   <= A;
            r_b   <= B;
            r_hi  <= '0;
            r_neg <= BNegate;
            r_op  <= ALUOp;
            r_cnt <= w_cnt_init;
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_op == OP_SHL || r_op == OP_SHR) begin
                r_a <= w_sh;
            end else if (r_op == OP_MUL) begin
                r_hi <= w_hi_nxt;
                r_b  <= w_lo_nxt;
            end
        end
    end

    assign w_bop     = r_neg ? ~r_b : r_b;
    assign w_add     = {1'b0, r_a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, r_neg};
    assign w_add_ovf = (r_a[WIDTH-1] == w_bop[WIDTH-1]) && (w_add[WIDTH-1] != r_a[WIDTH-1]);
    // SLT always compares against the raw B, so it uses its own subtractor.
    assign w_sub     = {1'b0, r_a} + {1'b0, ~r_b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_sub_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);

    assign w_sh     = (r_op == OP_SHL) ? (r_a << 1) : (r_a >> 1);
    assign w_sh_out = (r_op == OP_SHL) ? r_a[WIDTH-1] : r_a[0];

    // Multiplier bits sit in r_b and are consumed LSB first as the product shifts in.
    assign w_madd   = {1'b0, r_hi} + (r_b[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_hi_nxt = w_madd[WIDTH:1];
    assign w_lo_nxt = {w_madd[0], r_b[WIDTH-1:1]};

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (r_op)
            OP_AND: w_res = r_a & w_bop;
            OP_OR:  w_res = r_a | w_bop;
            OP_XOR: w_res = r_a ^ w_bop;
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_sub[WIDTH-1] ^ w_sub_ovf};
            OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = w_add_ovf;
            end
            OP_SHL, OP_SHR: begin
                if (r_cnt == '0) begin
                    w_res = r_a;
                end else begin
                    w_res = w_sh;
                    w_c   = w_sh_out;
                end
            end
            OP_MUL: begin
                w_res = w_lo_nxt;
                w_c   = |w_hi_nxt;
            end
            default: w_res = '0;
        endcase
    end

    // Completion edge: publish result and flags, pulse Done for one cycle
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Result   <= '0;
            CarryOut <= 1'b0;
            Zero     <= 1'b0;
            Overflow <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (r_state == S_RUN && w_last) begin
                Result   <= w_res;
                CarryOut <= w_c;
                Zero     <= (w_res == '0);
                Overflow <= w_v;
                Done     <= 1'b1;
            end
        end
    end

endmodule
